// File: rtl/wb_arbiter.sv
// Write-back arbiter: picks scalar, vector or one-entry buffer for RF and VRF each cycle.
// 0-cycle select/capture decisions; the vector side never stalls, the scalar side stalls on conflict.
module wb_arbiter #(
   parameter int STARVE_MAX = 8,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             scalar_rf_req,
   input  logic             scalar_vrf_req,
   input  logic             vector_rf_req,
   input  logic             vector_vrf_req,
   input  logic [4:0]       vector_pipeline_wbr,
   output logic             register_wb_sel,
   output logic             buffer_register_sel,
   output logic             buffer_register,
   output logic             vector_wb_sel,
   output logic             buffer_vector_sel,
   output logic             buffer_vector,
   output logic             scalar_stall,
   output logic             buf_reg_valid,
   output logic [4:0]       buf_reg_wbr,
   output logic             buf_vec_valid,
   output logic             vector_throttle,
   output logic [CNT_W-1:0] conflict_cnt
);

   localparam int SW = $clog2(STARVE_MAX + 1);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t           rf_state_q, rf_state_d;
   state_t           vrf_state_q, vrf_state_d;
   logic             rf_stall, vrf_stall, rf_coll, vrf_coll;
   logic [4:0]       buf_reg_wbr_q, buf_reg_wbr_d;
   logic [SW-1:0]    starve_q, starve_d;
   logic             throttle_q, throttle_d;
   logic [CNT_W-1:0] conflict_q, conflict_d;

   // RF arbitration; a FULL buffer always drains first so the entry stays the oldest write
   always_comb begin
      register_wb_sel     = 1'b0;
      buffer_register_sel = 1'b0;
      buffer_register     = 1'b0;
      rf_stall            = 1'b0;
      rf_coll             = 1'b0;
      rf_state_d          = rf_state_q;
      if (rst) begin
         rf_coll = scalar_rf_req & vector_rf_req;
         case (rf_state_q)
            EMPTY: begin
               register_wb_sel = vector_rf_req & ~scalar_rf_req;
               buffer_register = scalar_rf_req & vector_rf_req;
               rf_state_d      = (scalar_rf_req & vector_rf_req) ? FULL : EMPTY;
            end
            FULL: begin
               register_wb_sel     = 1'b1;
               buffer_register_sel = 1'b1;
               buffer_register     = vector_rf_req;
               rf_stall            = scalar_rf_req;
               rf_state_d          = vector_rf_req ? FULL : EMPTY;
            end
            default: rf_state_d = EMPTY;
         endcase
      end
   end

   always_comb begin
      vector_wb_sel     = 1'b0;
      buffer_vector_sel = 1'b0;
      buffer_vector     = 1'b0;
      vrf_stall         = 1'b0;
      vrf_coll          = 1'b0;
      vrf_state_d       = vrf_state_q;
      if (rst) begin
         vrf_coll = scalar_vrf_req & vector_vrf_req;
         case (vrf_state_q)
            EMPTY: begin
               vector_wb_sel = vector_vrf_req & ~scalar_vrf_req;
               buffer_vector = scalar_vrf_req & vector_vrf_req;
               vrf_state_d   = (scalar_vrf_req & vector_vrf_req) ? FULL : EMPTY;
            end
            FULL: begin
               vector_wb_sel     = 1'b1;
               buffer_vector_sel = 1'b1;
               buffer_vector     = vector_vrf_req;
               vrf_stall         = scalar_vrf_req;
               vrf_state_d       = vector_vrf_req ? FULL : EMPTY;
            end
            default: vrf_state_d = EMPTY;
         endcase
      end
   end

   always_comb begin
      scalar_stall  = rf_stall | vrf_stall;
      buf_reg_wbr_d = buffer_register ? vector_pipeline_wbr : buf_reg_wbr_q;
      starve_d      = '0;
      if (scalar_stall) begin
         starve_d = (starve_q == SW'(STARVE_MAX)) ? starve_q : starve_q + 1'b1;
      end
      // Throttle rises on the cycle after the counter hits the limit, drops after any unstalled cycle
      throttle_d = scalar_stall && (starve_d == SW'(STARVE_MAX));
      conflict_d = conflict_q;
      if ((rf_coll | vrf_coll) && (conflict_q != '1)) begin
         conflict_d = conflict_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rf_state_q    <= EMPTY;
         vrf_state_q   <= EMPTY;
         buf_reg_wbr_q <= '0;
         starve_q      <= '0;
         throttle_q    <= 1'b0;
         conflict_q    <= '0;
      end else begin
         rf_state_q    <= rf_state_d;
         vrf_state_q   <= vrf_state_d;
         buf_reg_wbr_q <= buf_reg_wbr_d;
         starve_q      <= starve_d;
         throttle_q    <= throttle_d;
         conflict_q    <= conflict_d;
      end
   end

   assign buf_reg_valid   = (rf_state_q == FULL);
   assign buf_vec_valid   = (vrf_state_q == FULL);
   assign buf_reg_wbr     = buf_reg_wbr_q;
   assign vector_throttle = throttle_q;
   assign conflict_cnt    = conflict_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: inputs change 1ns after posedge, outputs sampled 4ns after posedge.
module tb_wb_arbiter;

   logic       clk;
   logic       rst;
   logic       scalar_rf_req, scalar_vrf_req, vector_rf_req, vector_vrf_req;
   logic [4:0] vector_pipeline_wbr;
   logic       register_wb_sel, buffer_register_sel, buffer_register;
   logic       vector_wb_sel, buffer_vector_sel, buffer_vector;
   logic       scalar_stall, buf_reg_valid, buf_vec_valid, vector_throttle;
   logic [4:0] buf_reg_wbr;
   logic [3:0] conflict_cnt;

   int errors = 0;
   int checks = 0;

   wb_arbiter #(.STARVE_MAX(8), .CNT_W(4)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .scalar_rf_req       (scalar_rf_req),
      .scalar_vrf_req      (scalar_vrf_req),
      .vector_rf_req       (vector_rf_req),
      .vector_vrf_req      (vector_vrf_req),
      .vector_pipeline_wbr (vector_pipeline_wbr),
      .register_wb_sel     (register_wb_sel),
      .buffer_register_sel (buffer_register_sel),
      .buffer_register     (buffer_register),
      .vector_wb_sel       (vector_wb_sel),
      .buffer_vector_sel   (buffer_vector_sel),
      .buffer_vector       (buffer_vector),
      .scalar_stall        (scalar_stall),
      .buf_reg_valid       (buf_reg_valid),
      .buf_reg_wbr         (buf_reg_wbr),
      .buf_vec_valid       (buf_vec_valid),
      .vector_throttle     (vector_throttle),
      .conflict_cnt        (conflict_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Applies one cycle of requests and leaves time at the sampling point of that cycle
   task automatic set_in(input logic s_rf, input logic v_rf, input logic s_vrf, input logic v_vrf,
                         input logic [4:0] wbr);
      @(posedge clk);
      #1;
      scalar_rf_req       = s_rf;
      vector_rf_req       = v_rf;
      scalar_vrf_req      = s_vrf;
      vector_vrf_req      = v_vrf;
      vector_pipeline_wbr = wbr;
      #3;
   endtask

   task automatic test_reset();
      logic [18:0] obs;
      repeat (2) @(posedge clk);
      #1;
      obs = {register_wb_sel, buffer_register_sel, buffer_register, vector_wb_sel, buffer_vector_sel,
             buffer_vector, scalar_stall, buf_reg_valid, buf_reg_wbr, buf_vec_valid, vector_throttle, conflict_cnt};
      checks++; if (obs !== 19'd0) begin errors++; $display("FAIL reset_outputs: got %h want 0", obs); end
      rst = 1'b1;
      scalar_rf_req = 0; vector_rf_req = 0; scalar_vrf_req = 0; vector_vrf_req = 0;
      #3;
      checks++; if (buf_reg_valid !== 1'b0) begin errors++; $display("FAIL reset_buf_reg_valid: got %b want 0", buf_reg_valid); end
      checks++; if (conflict_cnt !== 4'd0) begin errors++; $display("FAIL reset_conflict_cnt: got %0d want 0", conflict_cnt); end
   endtask

   task automatic test_rf_collision();
      set_in(1, 1, 0, 0, 5'd7);
      checks++; if (register_wb_sel !== 1'b0) begin errors++; $display("FAIL coll_c0_sel: got %b want 0", register_wb_sel); end
      checks++; if (buffer_register !== 1'b1) begin errors++; $display("FAIL coll_c0_capture: got %b want 1", buffer_register); end
      checks++; if (scalar_stall !== 1'b0) begin errors++; $display("FAIL coll_c0_stall: got %b want 0", scalar_stall); end
      set_in(0, 0, 0, 0, 5'd0);
      checks++; if (register_wb_sel !== 1'b1) begin errors++; $display("FAIL coll_c1_sel: got %b want 1", register_wb_sel); end
      checks++; if (buffer_register_sel !== 1'b1) begin errors++; $display("FAIL coll_c1_bufsel: got %b want 1", buffer_register_sel); end
      checks++; if (buf_reg_wbr !== 5'd7) begin errors++; $display("FAIL coll_c1_wbr: got %0d want 7", buf_reg_wbr); end
      checks++; if (buf_reg_valid !== 1'b1) begin errors++; $display("FAIL coll_c1_valid: got %b want 1", buf_reg_valid); end
      checks++; if (buffer_register !== 1'b0) begin errors++; $display("FAIL coll_c1_capture: got %b want 0", buffer_register); end
      checks++; if (conflict_cnt !== 4'd1) begin errors++; $display("FAIL coll_c1_cnt: got %0d want 1", conflict_cnt); end
      set_in(0, 0, 0, 0, 5'd0);
      checks++; if (buf_reg_valid !== 1'b0) begin errors++; $display("FAIL coll_c2_valid: got %b want 0", buf_reg_valid); end
      checks++; if (register_wb_sel !== 1'b0) begin errors++; $display("FAIL coll_c2_sel: got %b want 0", register_wb_sel); end
   endtask

   task automatic test_drain_pending();
      set_in(1, 1, 0, 0, 5'd3);
      set_in(1, 0, 0, 0, 5'd0);
      checks++; if (scalar_stall !== 1'b1) begin errors++; $display("FAIL drain_stall: got %b want 1", scalar_stall); end
      checks++; if (register_wb_sel !== 1'b1) begin errors++; $display("FAIL drain_sel: got %b want 1", register_wb_sel); end
      checks++; if (buffer_register_sel !== 1'b1) begin errors++; $display("FAIL drain_bufsel: got %b want 1", buffer_register_sel); end
      checks++; if (buffer_register !== 1'b0) begin errors++; $display("FAIL drain_capture: got %b want 0", buffer_register); end
      set_in(1, 0, 0, 0, 5'd0);
      checks++; if (scalar_stall !== 1'b0) begin errors++; $display("FAIL drain_next_stall: got %b want 0", scalar_stall); end
      checks++; if (register_wb_sel !== 1'b0) begin errors++; $display("FAIL drain_next_sel: got %b want 0", register_wb_sel); end
      checks++; if (buf_reg_valid !== 1'b0) begin errors++; $display("FAIL drain_next_valid: got %b want 0", buf_reg_valid); end
      checks++; if (conflict_cnt !== 4'd2) begin errors++; $display("FAIL drain_cnt: got %0d want 2", conflict_cnt); end
   endtask

   task automatic test_back_to_back();
      set_in(0, 1, 0, 0, 5'd9);
      checks++; if (register_wb_sel !== 1'b1 || buffer_register_sel !== 1'b0 || buffer_register !== 1'b0) begin
         errors++; $display("FAIL direct_commit: got sel=%b bufsel=%b cap=%b want 1 0 0", register_wb_sel, buffer_register_sel, buffer_register); end
      set_in(1, 1, 0, 0, 5'd10);
      for (int i = 0; i < 4; i++) begin
         set_in(0, 1, 0, 0, 5'(11 + i));
         checks++; if (buffer_register !== 1'b1) begin errors++; $display("FAIL b2b_capture[%0d]: got %b want 1", i, buffer_register); end
         checks++; if (buffer_register_sel !== 1'b1) begin errors++; $display("FAIL b2b_bufsel[%0d]: got %b want 1", i, buffer_register_sel); end
         checks++; if (buf_reg_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, buf_reg_valid); end
         checks++; if (buf_reg_wbr !== 5'(10 + i)) begin errors++; $display("FAIL b2b_wbr[%0d]: got %0d want %0d", i, buf_reg_wbr, 10 + i); end
      end
      set_in(0, 0, 0, 0, 5'd0);
      checks++; if (register_wb_sel !== 1'b1 || buffer_register_sel !== 1'b1 || buffer_register !== 1'b0) begin
         errors++; $display("FAIL b2b_last_drain: got sel=%b bufsel=%b cap=%b want 1 1 0", register_wb_sel, buffer_register_sel, buffer_register); end
      checks++; if (buf_reg_wbr !== 5'd14) begin errors++; $display("FAIL b2b_last_wbr: got %0d want 14", buf_reg_wbr); end
      set_in(0, 0, 0, 0, 5'd0);
      checks++; if (buf_reg_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b want 0", buf_reg_valid); end
      checks++; if (conflict_cnt !== 4'd3) begin errors++; $display("FAIL b2b_cnt: got %0d want 3", conflict_cnt); end
   endtask

   task automatic test_vrf_independent();
      set_in(1, 0, 1, 1, 5'd0);
      checks++; if (register_wb_sel !== 1'b0 || vector_wb_sel !== 1'b0) begin
         errors++; $display("FAIL vrf_coll_sel: got rf=%b vrf=%b want 0 0", register_wb_sel, vector_wb_sel); end
      checks++; if (buffer_vector !== 1'b1 || buffer_register !== 1'b0) begin
         errors++; $display("FAIL vrf_coll_capture: got vec=%b reg=%b want 1 0", buffer_vector, buffer_register); end
      set_in(0, 1, 1, 0, 5'd0);
      checks++; if (scalar_stall !== 1'b1) begin errors++; $display("FAIL vrf_drain_stall: got %b want 1", scalar_stall); end
      checks++; if (register_wb_sel !== 1'b1 || buffer_register_sel !== 1'b0) begin
         errors++; $display("FAIL vrf_drain_rf_direct: got sel=%b bufsel=%b want 1 0", register_wb_sel, buffer_register_sel); end
      checks++; if (vector_wb_sel !== 1'b1 || buffer_vector_sel !== 1'b1) begin
         errors++; $display("FAIL vrf_drain_sel: got sel=%b bufsel=%b want 1 1", vector_wb_sel, buffer_vector_sel); end
      checks++; if (conflict_cnt !== 4'd4) begin errors++; $display("FAIL vrf_cnt: got %0d want 4", conflict_cnt); end
      set_in(1, 1, 1, 1, 5'd2);
      checks++; if (buf_vec_valid !== 1'b0 || scalar_stall !== 1'b0) begin
         errors++; $display("FAIL dual_coll: got vvalid=%b stall=%b want 0 0", buf_vec_valid, scalar_stall); end
      set_in(0, 0, 0, 0, 5'd0);
      checks++; if (conflict_cnt !== 4'd5) begin errors++; $display("FAIL dual_cnt: got %0d want 5", conflict_cnt); end
      checks++; if (buf_reg_valid !== 1'b1 || buf_vec_valid !== 1'b1) begin
         errors++; $display("FAIL dual_valid: got reg=%b vec=%b want 1 1", buf_reg_valid, buf_vec_valid); end
      set_in(0, 0, 0, 0, 5'd0);
   endtask

   task automatic test_starvation();
      logic exp_t;
      set_in(1, 1, 0, 0, 5'd1);
      checks++; if (scalar_stall !== 1'b0 || vector_throttle !== 1'b0) begin
         errors++; $display("FAIL starve_c0: got stall=%b thr=%b want 0 0", scalar_stall, vector_throttle); end
      for (int k = 1; k <= 10; k++) begin
         set_in(1, 1, 0, 0, 5'd1);
         exp_t = (k >= 9);
         checks++; if (scalar_stall !== 1'b1) begin errors++; $display("FAIL starve_stall[%0d]: got %b want 1", k, scalar_stall); end
         checks++; if (vector_throttle !== exp_t) begin errors++; $display("FAIL starve_throttle[%0d]: got %b want %b", k, vector_throttle, exp_t); end
      end
      set_in(0, 0, 0, 0, 5'd0);
      checks++; if (scalar_stall !== 1'b0 || vector_throttle !== 1'b1) begin
         errors++; $display("FAIL starve_release: got stall=%b thr=%b want 0 1", scalar_stall, vector_throttle); end
      set_in(0, 0, 0, 0, 5'd0);
      checks++; if (vector_throttle !== 1'b0) begin errors++; $display("FAIL starve_clear: got %b want 0", vector_throttle); end
   endtask

   task automatic test_saturation();
      logic [3:0] exp_c;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      #3;
      checks++; if (conflict_cnt !== 4'd0) begin errors++; $display("FAIL sat_reset: got %0d want 0", conflict_cnt); end
      for (int i = 0; i < 20; i++) begin
         if (i < 10) set_in(1, 1, 1, 1, 5'd4);
         else        set_in(1, 1, 0, 0, 5'd4);
         exp_c = (i > 15) ? 4'd15 : 4'(i);
         checks++; if (conflict_cnt !== exp_c) begin errors++; $display("FAIL sat_count[%0d]: got %0d want %0d", i, conflict_cnt, exp_c); end
      end
      set_in(0, 0, 0, 0, 5'd0);
      checks++; if (conflict_cnt !== 4'd15) begin errors++; $display("FAIL sat_final: got %0d want 15", conflict_cnt); end
      set_in(0, 0, 0, 0, 5'd0);
      checks++; if (conflict_cnt !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d want 15", conflict_cnt); end
   endtask

   initial begin
      rst = 1'b0;
      scalar_rf_req = 1; vector_rf_req = 1; scalar_vrf_req = 1; vector_vrf_req = 1;
      vector_pipeline_wbr = 5'd31;
      test_reset();
      test_rf_collision();
      test_drain_pending();
      test_back_to_back();
      test_vrf_independent();
      test_starvation();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
